// File: rtl/pipe_stage_buf_pkg.sv
// Shared definitions for the inter-stage pipeline buffers: control-bit layout
// and default kill mask.
package pipe_pkg;

  localparam int unsigned CTRL_REGWREN    = 0;
  localparam int unsigned CTRL_MEMWREN    = 1;
  localparam int unsigned CTRL_MULSEL_LSB = 2;
  localparam int unsigned CTRL_MULSEL_W   = 2;

  localparam int unsigned CTRL_W_DEFAULT = 4;

  // Zero only the write enables on bubbles; mulSel may stay stale.
  localparam logic [CTRL_W_DEFAULT-1:0] KILL_MASK_WR_ONLY = 4'b0011;

endpackage

// File: rtl/pipe_stage_buf_slot.sv
// One buffer slot: a valid bit plus payload register. Load wins over clear;
// clear drops only the valid bit so the payload keeps its last value.
module pipe_slot #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] dIn,
  output logic             valid,
  output logic [WIDTH-1:0] dOut
);

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      dOut  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      dOut  <= dIn;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pipe_stage_buf.sv
// Valid/ready pipeline register between two stages with flush, optional skid
// entry, kill-masked control on bubbles and a saturating bubble counter.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 96,
  parameter int unsigned CTRL_WIDTH = CTRL_W_DEFAULT,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned SKID       = 1,
  parameter logic [CTRL_WIDTH-1:0] CTRL_KILL_MASK = '1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [15:0]           bubble_cnt
);

  localparam int unsigned PW = CTRL_WIDTH + ADDR_WIDTH + DATA_WIDTH;

  logic          inReady;
  logic          inXfer;
  logic          outXfer;
  logic [PW-1:0] inPayload;

  logic          mainValid;
  logic          mainLoad;
  logic          mainClear;
  logic [PW-1:0] mainD;
  logic [PW-1:0] mainQ;

  logic [CTRL_WIDTH-1:0] mainCtrl;
  logic [15:0]           bubbleCnt;

  assign inPayload = {in_ctrl, in_addr, in_data};
  assign inXfer    = in_valid & inReady;
  assign outXfer   = mainValid & out_ready;

  pipe_slot #(.WIDTH(PW)) uMain (
    .clk   (clk),
    .reset (reset),
    .load  (mainLoad),
    .clear (mainClear),
    .dIn   (mainD),
    .valid (mainValid),
    .dOut  (mainQ)
  );

  generate
    if (SKID != 0) begin : gSkid
      logic          skidValid;
      logic          skidLoad;
      logic          skidClear;
      logic [PW-1:0] skidQ;

      pipe_slot #(.WIDTH(PW)) uSkid (
        .clk   (clk),
        .reset (reset),
        .load  (skidLoad),
        .clear (skidClear),
        .dIn   (inPayload),
        .valid (skidValid),
        .dOut  (skidQ)
      );

      // Ready depends only on registered skid state, never on out_ready.
      assign inReady = ~skidValid & ~flush;

      // A held skid entry means inReady=0, so the skid-to-main move never
      // collides with a new input.
      always_comb begin
        mainLoad  = 1'b0;
        mainClear = 1'b0;
        mainD     = inPayload;
        skidLoad  = 1'b0;
        skidClear = 1'b0;
        if (flush) begin
          mainClear = 1'b1;
          skidClear = 1'b1;
        end else if (outXfer && skidValid) begin
          mainLoad  = 1'b1;
          mainD     = skidQ;
          skidClear = 1'b1;
        end else if (inXfer && (!mainValid || outXfer)) begin
          mainLoad = 1'b1;
        end else if (inXfer) begin
          skidLoad = 1'b1;
        end else if (outXfer) begin
          mainClear = 1'b1;
        end
      end
    end else begin : gNoSkid
      assign inReady = (~mainValid | out_ready) & ~flush;

      always_comb begin
        mainD     = inPayload;
        mainLoad  = inXfer;
        mainClear = flush | (outXfer & ~inXfer);
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      bubbleCnt <= '0;
    end else if (!mainValid && out_ready && (bubbleCnt != '1)) begin
      bubbleCnt <= bubbleCnt + 16'd1;
    end
  end

  assign mainCtrl   = mainQ[PW-1 -: CTRL_WIDTH];
  assign in_ready   = inReady;
  assign out_valid  = mainValid;
  assign out_ctrl   = mainCtrl & ~(CTRL_KILL_MASK & {CTRL_WIDTH{~mainValid}});
  assign out_addr   = mainQ[DATA_WIDTH +: ADDR_WIDTH];
  assign out_data   = mainQ[DATA_WIDTH-1:0];
  assign bubble_cnt = bubbleCnt;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: three instances (skid, skid with
// write-only kill mask, no skid) share one stimulus stream.
module tb_pipe_stage_buf;
  import pipe_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        inValid;
  logic [3:0]  inCtrl;
  logic [3:0]  inAddr;
  logic [95:0] inData;
  logic        outReady;

  logic        aInReady, bInReady, cInReady;
  logic        aOutValid, bOutValid, cOutValid;
  logic [3:0]  aOutCtrl, bOutCtrl, cOutCtrl;
  logic [3:0]  aOutAddr, bOutAddr, cOutAddr;
  logic [95:0] aOutData, bOutData, cOutData;
  logic [15:0] aBubble, bBubble, cBubble;

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  pipe_stage_buf #(.DATA_WIDTH(96), .CTRL_WIDTH(4), .ADDR_WIDTH(4), .SKID(1)) uA (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(inValid), .in_ready(aInReady),
    .in_ctrl(inCtrl), .in_addr(inAddr), .in_data(inData), .out_valid(aOutValid),
    .out_ready(outReady), .out_ctrl(aOutCtrl), .out_addr(aOutAddr), .out_data(aOutData),
    .bubble_cnt(aBubble)
  );

  pipe_stage_buf #(.DATA_WIDTH(96), .CTRL_WIDTH(4), .ADDR_WIDTH(4), .SKID(1),
                   .CTRL_KILL_MASK(KILL_MASK_WR_ONLY)) uB (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(inValid), .in_ready(bInReady),
    .in_ctrl(inCtrl), .in_addr(inAddr), .in_data(inData), .out_valid(bOutValid),
    .out_ready(outReady), .out_ctrl(bOutCtrl), .out_addr(bOutAddr), .out_data(bOutData),
    .bubble_cnt(bBubble)
  );

  pipe_stage_buf #(.DATA_WIDTH(96), .CTRL_WIDTH(4), .ADDR_WIDTH(4), .SKID(0)) uC (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(inValid), .in_ready(cInReady),
    .in_ctrl(inCtrl), .in_addr(inAddr), .in_data(inData), .out_valid(cOutValid),
    .out_ready(outReady), .out_ctrl(cOutCtrl), .out_addr(cOutAddr), .out_data(cOutData),
    .bubble_cnt(cBubble)
  );

  task automatic checkEq(input string tag, input logic [95:0] got, input logic [95:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset;
    reset    = 1'b1;
    flush    = 1'b0;
    inValid  = 1'b0;
    outReady = 1'b0;
    inCtrl   = '0;
    inAddr   = '0;
    inData   = '0;
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    // Reset state and streaming
    doReset();
    checkEq("rst_valid", aOutValid, 1'b0);
    checkEq("rst_ctrl", aOutCtrl, 4'h0);
    checkEq("rst_addr", aOutAddr, 4'h0);
    checkEq("rst_data", aOutData, 96'h0);
    checkEq("rst_ready", aInReady, 1'b1);
    checkEq("rst_bubble", aBubble, 16'h0);
    checkEq("rst_ready_c", cInReady, 1'b1);

    inValid = 1'b1; outReady = 1'b1; inCtrl = 4'b0001; inAddr = 4'h5; inData = 96'd1;
    #1;
    checkEq("str_pre_valid", aOutValid, 1'b0);
    tick();
    checkEq("str_valid1", aOutValid, 1'b1);
    checkEq("str_data1", aOutData, 96'd1);
    checkEq("str_addr1", aOutAddr, 4'h5);
    checkEq("str_ctrl1", aOutCtrl, 4'b0001);
    checkEq("str_ready1", aInReady, 1'b1);
    inData = 96'd2;
    tick();
    checkEq("str_data2", aOutData, 96'd2);
    checkEq("str_ready2", aInReady, 1'b1);
    checkEq("str_data2_c", cOutData, 96'd2);
    inData = 96'd3;
    tick();
    checkEq("str_data3", aOutData, 96'd3);
    checkEq("str_valid3", aOutValid, 1'b1);
    inValid = 1'b0;
    tick();
    checkEq("str_drained", aOutValid, 1'b0);
    checkEq("str_killctrl", aOutCtrl, 4'h0);
    checkEq("str_bubble", aBubble, 16'd1);

    // Back-pressure fills main then skid; order kept on release
    doReset();
    inValid = 1'b1; inCtrl = 4'b0001; inAddr = 4'h1; inData = 96'hA;
    tick();
    checkEq("bp_mainA", aOutData, 96'hA);
    checkEq("bp_ready1", aInReady, 1'b1);
    inData = 96'hB;
    tick();
    checkEq("bp_full_ready", aInReady, 1'b0);
    checkEq("bp_holdA", aOutData, 96'hA);
    inData = 96'hC;
    tick();
    checkEq("bp_stableA", aOutData, 96'hA);
    checkEq("bp_stable_valid", aOutValid, 1'b1);
    checkEq("bp_still_full", aInReady, 1'b0);
    outReady = 1'b1;
    tick();
    checkEq("bp_outB", aOutData, 96'hB);
    checkEq("bp_ready_again", aInReady, 1'b1);
    tick();
    checkEq("bp_outC", aOutData, 96'hC);
    checkEq("bp_validC", aOutValid, 1'b1);
    inValid = 1'b0;
    tick();
    checkEq("bp_empty", aOutValid, 1'b0);

    // Flush with both slots full
    doReset();
    inValid = 1'b1; inCtrl = 4'b0011; inAddr = 4'h2; inData = 96'h10;
    tick();
    inData = 96'h11;
    tick();
    inData = 96'h12; flush = 1'b1;
    #1;
    checkEq("fl_ready_in_flush", aInReady, 1'b0);
    tick();
    flush = 1'b0; inValid = 1'b0;
    #1;
    checkEq("fl_valid", aOutValid, 1'b0);
    checkEq("fl_ctrl", aOutCtrl, 4'h0);
    checkEq("fl_ready", aInReady, 1'b1);
    tick();
    checkEq("fl_no_capture", aOutValid, 1'b0);

    // Kill mask leaves mulSel visible on a bubble
    doReset();
    inValid = 1'b1; outReady = 1'b1; inCtrl = 4'b1111; inAddr = 4'h9; inData = 96'h20;
    tick();
    checkEq("km_valid_ctrl", bOutCtrl, 4'b1111);
    inValid = 1'b0;
    tick();
    checkEq("km_invalid", bOutValid, 1'b0);
    checkEq("km_ctrl_b", bOutCtrl, 4'b1100);
    checkEq("km_ctrl_a", aOutCtrl, 4'b0000);
    checkEq("km_addr", bOutAddr, 4'h9);
    checkEq("km_data", bOutData, 96'h20);

    // Single-slot variant
    doReset();
    inValid = 1'b1; outReady = 1'b1; inCtrl = 4'b0001; inAddr = 4'h3; inData = 96'h31;
    #1;
    checkEq("s0_ready_empty", cInReady, 1'b1);
    tick();
    checkEq("s0_data31", cOutData, 96'h31);
    inData = 96'h32;
    #1;
    checkEq("s0_ready_drain", cInReady, 1'b1);
    tick();
    checkEq("s0_data32", cOutData, 96'h32);
    inData = 96'h33; outReady = 1'b0;
    #1;
    checkEq("s0_ready_blocked", cInReady, 1'b0);
    tick();
    checkEq("s0_hold32", cOutData, 96'h32);
    outReady = 1'b1;
    #1;
    checkEq("s0_ready_follow", cInReady, 1'b1);
    tick();
    checkEq("s0_data33", cOutData, 96'h33);
    checkEq("s0_valid33", cOutValid, 1'b1);

    // Bubble counter saturation
    doReset();
    checkEq("bc_rst", aBubble, 16'h0);
    outReady = 1'b1;
    force uA.bubbleCnt = 16'hFFFE;
    #1;
    release uA.bubbleCnt;
    tick();
    checkEq("bc_sat1", aBubble, 16'hFFFF);
    tick();
    checkEq("bc_sat2", aBubble, 16'hFFFF);
    tick();
    checkEq("bc_sat3", aBubble, 16'hFFFF);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checkEq("bc_reset", aBubble, 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
